// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: RAM handshake states and the arbiter FSM states.
package cpu_types_pkg;

    // State reported by the RAM model on every cycle.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter ownership of the shared RAM port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data memory.
// Data side has priority; a streak limiter forces a fetch grant after
// MAX_DSTREAK back-to-back data grants that happened while fetch was waiting.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_DSTREAK = 4,
    parameter int ERR_W       = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             iREN,
    input  logic [31:0]      iaddr,
    output logic             iwait,
    output logic [31:0]      iload,
    input  logic             dREN,
    input  logic             dWEN,
    input  logic [31:0]      daddr,
    input  logic [31:0]      dstore,
    output logic             dwait,
    output logic [31:0]      dload,
    output logic             ramREN,
    output logic             ramWEN,
    output logic [31:0]      ramaddr,
    output logic [31:0]      ramstore,
    input  logic [31:0]      ramload,
    input  ramstate_t        ramstate,
    output logic [1:0]       grant,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int STREAK_W = $clog2(MAX_DSTREAK) + 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

    arb_state_t          state;
    arb_state_t          nextState;
    logic [STREAK_W-1:0] dstreak;
    logic [STREAK_W-1:0] nextDstreak;
    logic [ERR_W-1:0]    errCnt;
    logic [ERR_W-1:0]    nextErrCnt;
    logic                dataReq;
    logic                grantedReq;

    // Request of each side and whether the current owner still wants the port.
    always_comb begin
        dataReq    = dREN | dWEN;
        grantedReq = ((state == IGNT) && iREN) || ((state == DGNT) && dataReq);
    end

    // State, streak and error registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            dstreak <= '0;
            errCnt  <= '0;
        end else begin
            state   <= nextState;
            dstreak <= nextDstreak;
            errCnt  <= nextErrCnt;
        end
    end

    // Arbitration in IDLE; completion, abort and error retry while granted.
    always_comb begin
        nextState   = state;
        nextDstreak = dstreak;
        nextErrCnt  = errCnt;
        case (state)
            IDLE: begin
                if (dataReq && (!iREN || (dstreak < STREAK_MAX))) begin
                    nextState   = DGNT;
                    nextDstreak = iREN ? dstreak + 1'b1 : '0;
                end else if (iREN) begin
                    nextState   = IGNT;
                    nextDstreak = '0;
                end
            end
            IGNT, DGNT: begin
                if (!grantedReq || (ramstate == ACCESS)) begin
                    nextState = IDLE;
                end else if ((ramstate == ERROR) && (errCnt != '1)) begin
                    nextErrCnt = errCnt + 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // RAM port and per-side handshake driven from the owner and its live inputs.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        grant    = 2'b00;
        case (state)
            IGNT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                grant   = 2'b01;
                if (iREN && (ramstate == ACCESS)) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                grant    = 2'b10;
                if (dWEN) begin
                    ramWEN = 1'b1;
                end else begin
                    ramREN = 1'b1;
                end
                if (dataReq && (ramstate == ACCESS)) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            default: ;
        endcase
    end

    assign err_cnt = errCnt;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vectors plus an
// ownership model compared against the DUT on every falling edge.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int MAX_DSTREAK = 4;
    localparam int ERR_W       = 8;
    localparam int ERR_MAX     = 255;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = '0;
    ramstate_t   ramstate = FREE;
    logic [1:0]  grant;
    logic [ERR_W-1:0] err_cnt;

    int assertCount = 0;
    int failCount   = 0;
    bit checkEnable = 1'b0;

    // Model: who owns the port (0 none, 1 fetch, 2 data), streak, errors.
    int owner  = 0;
    int streak = 0;
    int errs   = 0;

    int expSeq[12] = '{0, 2, 0, 2, 0, 2, 0, 2, 0, 1, 0, 2};

    memory_arbiter #(.MAX_DSTREAK(MAX_DSTREAK), .ERR_W(ERR_W)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .grant(grant), .err_cnt(err_cnt)
    );

    // 10 ns clock.
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic dw,
                                 input logic [31:0] da, input logic [31:0] ds,
                                 input ramstate_t rs, input logic [31:0] rl);
        iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
        daddr = da; dstore = ds; ramstate = rs; ramload = rl;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    // Ownership model advanced on every rising edge from the inputs held there.
    always @(posedge CLK) begin
        bit wantsData;
        bit ownerWants;
        wantsData = dREN || dWEN;
        if (RST) begin
            owner = 0; streak = 0; errs = 0;
        end else if (owner == 0) begin
            if (wantsData && (!iREN || streak < MAX_DSTREAK)) begin
                owner  = 2;
                streak = iREN ? streak + 1 : 0;
            end else if (iREN) begin
                owner  = 1;
                streak = 0;
            end
        end else begin
            ownerWants = (owner == 1) ? iREN : wantsData;
            if (!ownerWants || ramstate == ACCESS) owner = 0;
            else if (ramstate == ERROR && errs < ERR_MAX) errs = errs + 1;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge CLK) begin
        if (checkEnable) begin
            bit iDone;
            bit dDone;
            iDone = (owner == 1) && iREN && (ramstate == ACCESS);
            dDone = (owner == 2) && (dREN || dWEN) && (ramstate == ACCESS);
            checkOutput("m.grant",    {30'd0, grant}, owner);
            checkOutput("m.ramREN",   {31'd0, ramREN}, (owner == 1) || (owner == 2 && !dWEN));
            checkOutput("m.ramWEN",   {31'd0, ramWEN}, (owner == 2) && dWEN);
            checkOutput("m.ramaddr",  ramaddr, (owner == 1) ? iaddr : (owner == 2) ? daddr : 32'd0);
            checkOutput("m.ramstore", ramstore, (owner == 2) ? dstore : 32'd0);
            checkOutput("m.iwait",    {31'd0, iwait}, !iDone);
            checkOutput("m.dwait",    {31'd0, dwait}, !dDone);
            checkOutput("m.iload",    iload, iDone ? ramload : 32'd0);
            checkOutput("m.dload",    dload, dDone ? ramload : 32'd0);
            checkOutput("m.err_cnt",  {24'd0, err_cnt}, errs);
        end
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        RST = 1'b1;
        nextCycle();
        nextCycle();
        RST = 1'b0;
        checkEnable = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
        checkOutput("rst.grant", {30'd0, grant}, 0);
        checkOutput("rst.ramREN", {31'd0, ramREN}, 0);
        checkOutput("rst.iwait", {31'd0, iwait}, 1);
        checkOutput("rst.err_cnt", {24'd0, err_cnt}, 0);

        // Instruction read alone.
        applyStimulus(1, 32'h40, 0, 0, 0, 0, FREE, 0);
        checkOutput("t1.idle.grant", {30'd0, grant}, 0);
        nextCycle();
        applyStimulus(1, 32'h40, 0, 0, 0, 0, BUSY, 0);
        checkOutput("t1.grant", {30'd0, grant}, 1);
        checkOutput("t1.ramaddr", ramaddr, 32'h40);
        checkOutput("t1.busy.iwait", {31'd0, iwait}, 1);
        nextCycle();
        applyStimulus(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'h8C010004);
        checkOutput("t1.iwait", {31'd0, iwait}, 0);
        checkOutput("t1.iload", iload, 32'h8C010004);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
        checkOutput("t1.after.grant", {30'd0, grant}, 0);
        nextCycle();

        // Simultaneous requests: data first, then fetch.
        applyStimulus(1, 32'h44, 1, 0, 32'h100, 0, FREE, 0);
        nextCycle();
        applyStimulus(1, 32'h44, 1, 0, 32'h100, 0, BUSY, 0);
        checkOutput("t2.grant", {30'd0, grant}, 2);
        checkOutput("t2.ramREN", {31'd0, ramREN}, 1);
        checkOutput("t2.ramaddr", ramaddr, 32'h100);
        nextCycle();
        applyStimulus(1, 32'h44, 1, 0, 32'h100, 0, ACCESS, 32'h55);
        checkOutput("t2.dwait", {31'd0, dwait}, 0);
        checkOutput("t2.iwait", {31'd0, iwait}, 1);
        nextCycle();
        applyStimulus(1, 32'h44, 0, 0, 0, 0, FREE, 0);
        checkOutput("t2.bubble", {30'd0, grant}, 0);
        nextCycle();
        applyStimulus(1, 32'h44, 0, 0, 0, 0, ACCESS, 32'h77);
        checkOutput("t2.igrant", {30'd0, grant}, 1);
        checkOutput("t2.iload", iload, 32'h77);
        nextCycle();

        // Starvation limiter with single-cycle RAM.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 32'h48, 1, 0, 32'h300, 0, ACCESS, 32'h1234);
            checkOutput($sformatf("t3.seq[%0d]", i), {30'd0, grant}, expSeq[i]);
            nextCycle();
        end

        // Write wins over read.
        applyStimulus(0, 0, 1, 1, 32'h200, 32'hDEADBEEF, FREE, 0);
        nextCycle();
        applyStimulus(0, 0, 1, 1, 32'h200, 32'hDEADBEEF, BUSY, 0);
        checkOutput("t4.ramWEN", {31'd0, ramWEN}, 1);
        checkOutput("t4.ramREN", {31'd0, ramREN}, 0);
        checkOutput("t4.ramstore", ramstore, 32'hDEADBEEF);
        nextCycle();
        applyStimulus(0, 0, 1, 1, 32'h200, 32'hDEADBEEF, ACCESS, 0);
        checkOutput("t4.dwait", {31'd0, dwait}, 0);
        nextCycle();

        // Fetch abort during BUSY.
        applyStimulus(1, 32'h80, 0, 0, 0, 0, FREE, 0);
        nextCycle();
        applyStimulus(0, 32'h80, 0, 0, 0, 0, BUSY, 0);
        checkOutput("t5.abort.iwait", {31'd0, iwait}, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, ACCESS, 0);
        checkOutput("t5.abort.grant", {30'd0, grant}, 0);
        checkOutput("t5.abort.iwait2", {31'd0, iwait}, 1);
        nextCycle();

        // Three ERROR cycles, then completion.
        applyStimulus(0, 0, 1, 0, 32'h10, 0, FREE, 0);
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 0, 32'h10, 0, ERROR, 0);
            nextCycle();
        end
        applyStimulus(0, 0, 1, 0, 32'h10, 0, ACCESS, 32'hABCD);
        checkOutput("t5.err3", {24'd0, err_cnt}, 3);
        checkOutput("t5.err.dwait", {31'd0, dwait}, 0);
        nextCycle();

        // Saturation of the error counter.
        applyStimulus(0, 0, 1, 0, 32'h14, 0, FREE, 0);
        nextCycle();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(0, 0, 1, 0, 32'h14, 0, ERROR, 0);
            nextCycle();
        end
        applyStimulus(0, 0, 1, 0, 32'h14, 0, ACCESS, 0);
        checkOutput("t5.sat", {24'd0, err_cnt}, 255);
        nextCycle();

        // Reset coinciding with ACCESS: wait pulse visible, state still cleared.
        applyStimulus(0, 0, 1, 0, 32'h20, 0, FREE, 0);
        nextCycle();
        RST = 1'b1;
        applyStimulus(0, 0, 1, 0, 32'h20, 0, ACCESS, 32'h99);
        checkOutput("t6.rstacc.dwait", {31'd0, dwait}, 0);
        nextCycle();
        RST = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
        checkOutput("t6.rstacc.grant", {30'd0, grant}, 0);
        checkOutput("t6.rstacc.err", {24'd0, err_cnt}, 0);
        nextCycle();

        // Reset mid-DGNT with a built-up streak and RAM BUSY.
        applyStimulus(1, 32'h60, 1, 0, 32'h24, 0, FREE, 0);
        nextCycle();
        applyStimulus(0, 0, 1, 0, 32'h24, 0, ERROR, 0);
        nextCycle();
        RST = 1'b1;
        applyStimulus(0, 0, 1, 0, 32'h24, 0, BUSY, 0);
        checkOutput("t6.pre.grant", {30'd0, grant}, 2);
        checkOutput("t6.pre.err", {24'd0, err_cnt}, 1);
        nextCycle();
        RST = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, BUSY, 0);
        checkOutput("t6.ramREN", {31'd0, ramREN}, 0);
        checkOutput("t6.ramWEN", {31'd0, ramWEN}, 0);
        checkOutput("t6.grant", {30'd0, grant}, 0);
        checkOutput("t6.err", {24'd0, err_cnt}, 0);

        // A cleared streak allows the full four data grants again.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 32'h64, 1, 0, 32'h28, 0, ACCESS, 32'h4321);
            checkOutput($sformatf("t6.seq[%0d]", i), {30'd0, grant}, expSeq[i]);
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
        nextCycle();
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
